key_search_sequencer: RTL

KEY_SEARCH_SEQUENCER -- requirements
Module: key_search_sequencer

---
 rtl/key_search_sequencer_if.sv | 33 +++
 rtl/key_search_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/key_search_sequencer_if.sv
// Handshake/bus bundle for key_search_sequencer.
// Host side:       search_start, search_abort, key_lo, key_hi -> sequencer;
//                  busy, found, exhausted, attempts <- sequencer.
// Controller side: Decrypt_done, Key_Valid -> sequencer;
//                  Controller_Start, Finish_ack, key <- sequencer.
// master: the sequencer.  slave: the environment (host plus decrypt controller).
interface key_search_sequencer_if #(
    parameter int unsigned KEY_W = 24
);
    logic             search_start;
    logic             search_abort;
    logic [KEY_W-1:0] key_lo;
    logic [KEY_W-1:0] key_hi;
    logic             Decrypt_done;
    logic             Key_Valid;
    logic             Controller_Start;
    logic             Finish_ack;
    logic [KEY_W-1:0] key;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic [KEY_W:0]   attempts;

    modport master (
        input  search_start, search_abort, key_lo, key_hi, Decrypt_done, Key_Valid,
        output Controller_Start, Finish_ack, key, busy, found, exhausted, attempts
    );

    modport slave (
        output search_start, search_abort, key_lo, key_hi, Decrypt_done, Key_Valid,
        input  Controller_Start, Finish_ack, key, busy, found, exhausted, attempts
    );
endinterface

// File: rtl/key_search_sequencer.sv
// Brute-force RC4 key search sequencer. Walks key from key_lo to key_hi (inclusive),
// launching one decrypt attempt per key and stopping on the first valid key, at the
// end of the range, or after an abort request.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - key_search_sequencer_if.master (host controls/status, decrypt handshake, key)
// All outputs are registered.
module key_search_sequencer #(
    parameter int unsigned KEY_W = 24
) (
    input logic                   clk,
    input logic                   rst_n,
    key_search_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StAck,
        StRelease,
        StNext,
        StDoneFound,
        StDoneExhausted
    } state_e;

    localparam logic [KEY_W-1:0] KeyOne = {{(KEY_W-1){1'b0}}, 1'b1};
    localparam logic [KEY_W:0]   CntOne = {{KEY_W{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] hi_q;
    logic [KEY_W:0]   attempts_q;
    logic             hit_q;
    logic             abort_q;
    logic             ctrl_start_q;
    logic             finish_ack_q;
    logic             busy_q;
    logic             found_q;
    logic             exhausted_q;

    logic             idle_like;
    logic             start_ok;

    // States in which a new search may be launched (also the non-busy states).
    assign idle_like = (state_q == StIdle) || (state_q == StDoneFound) ||
                       (state_q == StDoneExhausted);
    assign start_ok  = idle_like && bus.search_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDoneFound, StDoneExhausted: begin
                if (bus.search_start) state_d = StLoad;
            end
            // key_q already holds the latched key_lo here.
            StLoad:    state_d = (key_q > hi_q) ? StDoneExhausted : StStart;
            StStart:   state_d = StWait;
            StWait:    if (bus.Decrypt_done) state_d = StAck;
            StAck:     state_d = StRelease;
            // Wait out a lingering done so the next attempt cannot see a stale one.
            StRelease: if (!bus.Decrypt_done) state_d = StNext;
            StNext: begin
                if (hit_q)              state_d = StDoneFound;
                else if (abort_q)       state_d = StDoneExhausted;
                else if (key_q == hi_q) state_d = StDoneExhausted;
                else                    state_d = StStart;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            key_q        <= '0;
            hi_q         <= '0;
            attempts_q   <= '0;
            hit_q        <= 1'b0;
            abort_q      <= 1'b0;
            ctrl_start_q <= 1'b0;
            finish_ack_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            // Outputs decoded from the next state so they line up with state_q.
            ctrl_start_q <= (state_d == StStart);
            finish_ack_q <= (state_d == StAck);
            found_q      <= (state_d == StDoneFound);
            exhausted_q  <= (state_d == StDoneExhausted);
            busy_q       <= !((state_d == StIdle) || (state_d == StDoneFound) ||
                              (state_d == StDoneExhausted));

            if (start_ok) begin
                key_q      <= bus.key_lo;
                hi_q       <= bus.key_hi;
                attempts_q <= '0;
                hit_q      <= 1'b0;
                abort_q    <= 1'b0;
            end

            // Sticky; only consulted in NEXT so the in-flight handshake completes.
            if (!idle_like && bus.search_abort) abort_q <= 1'b1;

            if ((state_q == StWait) && bus.Decrypt_done) begin
                hit_q <= bus.Key_Valid;
                if (!attempts_q[KEY_W]) attempts_q <= attempts_q + CntOne;
            end

            // Only increments when NEXT loops back, i.e. key_q != hi_q: no wrap at the top.
            if ((state_q == StNext) && (state_d == StStart)) key_q <= key_q + KeyOne;
        end
    end

    assign bus.Controller_Start = ctrl_start_q;
    assign bus.Finish_ack       = finish_ack_q;
    assign bus.key              = key_q;
    assign bus.busy             = busy_q;
    assign bus.found            = found_q;
    assign bus.exhausted        = exhausted_q;
    assign bus.attempts         = attempts_q;

endmodule
